// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   uart_state_t      - transmitter FSM state encoding (IDLE/START/DATA/STOP)
//   UART_DATA_BITS    - payload bits per frame
//   UART_*_LVL        - line levels for start, stop and idle
package uart_pkg;

   typedef logic [1:0] uart_state_t;

   localparam uart_state_t ST_IDLE  = 2'd0;
   localparam uart_state_t ST_START = 2'd1;
   localparam uart_state_t ST_DATA  = 2'd2;
   localparam uart_state_t ST_STOP  = 2'd3;

   localparam int unsigned UART_DATA_BITS = 8;
   localparam logic        UART_START_LVL = 1'b0;
   localparam logic        UART_STOP_LVL  = 1'b1;
   localparam logic        UART_IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_core_if.sv
// uart_tx_core_if: byte push channel from the register block to the
// transmitter.
//   in_data  - byte to transmit
//   in_valid - in_data is valid
//   in_ready - transmitter buffer can accept
// master = producer (register block), slave = uart_tx_core.
interface uart_tx_core_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] in_data;
   logic                      in_valid;
   logic                      in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/uart_tx_core_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, reset       - clock, synchronous active-high reset (empties FIFO)
//   wr_en, wr_data   - write at tail; ignored while full
//   rd_en, rd_data   - rd_data always shows the head; rd_en pops it
//   full, empty      - occupancy flags
//   count            - entries currently stored
// DEPTH must be a power of two so the pointers wrap by overflow.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: buffered 8N1 UART transmitter, LSB first.
//   clk, reset  - clock, synchronous active-high reset
//   in_if       - byte push channel (slave side): in_data/in_valid/in_ready
//   tx          - serial line, idle high, registered
//   tx_done     - one-cycle pulse during the final cycle of each stop bit
//   busy        - frame on the line or bytes waiting
//   fifo_count  - bytes buffered, excluding the one being shifted
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 20,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   uart_tx_core_if.slave    in_if,
   output logic             tx,
   output logic             tx_done,
   output logic             busy,
   output logic [CNT_W-1:0] fifo_count
);

   localparam int unsigned         BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0]   BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]          LAST_BIT  = 3'(UART_DATA_BITS - 1);

   uart_state_t               state;
   logic [BAUD_W-1:0]         baud;
   logic                      baud_last;
   logic [2:0]                bit_idx;
   logic [UART_DATA_BITS-1:0] shift;

   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      fifo_rd;
   logic [UART_DATA_BITS-1:0] fifo_head;

   sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (in_if.in_valid),
      .wr_data (in_if.in_data),
      .rd_en   (fifo_rd),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign in_if.in_ready = !fifo_full;
   assign baud_last      = (baud == BAUD_LAST);

   // A frame is loaded either from idle or straight out of the last stop
   // cycle, which is what makes back-to-back frames gapless.
   assign fifo_rd = !fifo_empty &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && baud_last));

   assign tx_done = (state == ST_STOP) && baud_last;
   assign busy    = (state != ST_IDLE) || (fifo_count != '0);

   // tx is registered with the level of the state being entered, so the
   // line changes on the same edge as the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= UART_IDLE_LVL;
      end else begin
         case (state)
            ST_IDLE: begin
               tx <= UART_IDLE_LVL;
               if (fifo_rd) begin
                  shift <= fifo_head;
                  baud  <= '0;
                  tx    <= UART_START_LVL;
                  state <= ST_START;
               end
            end

            ST_START: begin
               if (baud_last) begin
                  baud    <= '0;
                  bit_idx <= '0;
                  tx      <= shift[0];
                  state   <= ST_DATA;
               end else begin
                  baud <= baud + 1'b1;
               end
            end

            ST_DATA: begin
               if (baud_last) begin
                  baud <= '0;
                  if (bit_idx == LAST_BIT) begin
                     tx    <= UART_STOP_LVL;
                     state <= ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end

            ST_STOP: begin
               if (baud_last) begin
                  baud <= '0;
                  if (fifo_rd) begin
                     shift <= fifo_head;
                     tx    <= UART_START_LVL;
                     state <= ST_START;
                  end else begin
                     tx    <= UART_IDLE_LVL;
                     state <= ST_IDLE;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end

            default: begin
               tx    <= UART_IDLE_LVL;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed sequence with random payloads, checked against a
// frame-timer reference model and an independent mid-bit line decoder.
module tb_uart_tx_core;

   localparam int CPB   = 20;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk;
   logic       reset;
   logic       tx;
   logic       tx_done;
   logic       busy;
   logic [2:0] fifo_count;

   uart_tx_core_if bus ();

   uart_tx_core #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_if      (bus),
      .tx         (tx),
      .tx_done    (tx_done),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: a queue of buffered bytes plus a frame timer counting
   // the cycles left on the line for the byte in flight.
   int          cyc = 0;
   logic [7:0]  mq[$];
   logic [7:0]  exp_done[$];
   logic [7:0]  m_byte;
   int          m_left = 0;
   bit          m_push;
   bit          chk_en = 0;

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         mq.delete();
         m_left = 0;
      end else begin
         m_push = bus.in_valid && (mq.size() < DEPTH);
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) exp_done.push_back(m_byte);
         end
         if (m_left == 0 && mq.size() > 0) begin
            m_byte = mq.pop_front();
            m_left = FRAME;
         end
         if (m_push) mq.push_back(bus.in_data);
      end
   end

   function automatic logic exp_tx();
      int p, b;
      if (m_left == 0) return 1'b1;
      p = FRAME - m_left;
      b = p / CPB;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return m_byte[b-1];
   endfunction

   // Line decoder, pulse counters and per-cycle model comparison.
   bit          mon_act = 0;
   int          mon_cnt = 0;
   logic [7:0]  mon_byte;
   logic [7:0]  rx[$];
   int          fall_cyc = 0;
   int          fr_err = 0;
   int          done_n = 0;
   int          done_cyc[$];
   int          dut_acc = 0;

   always @(negedge clk) begin
      if (reset) begin
         mon_act = 0;
      end else if (!mon_act) begin
         if (tx === 1'b0) begin
            mon_act  = 1;
            mon_cnt  = 0;
            fall_cyc = cyc;
         end
      end else begin
         mon_cnt++;
         if (mon_cnt % CPB == CPB / 2) begin
            if (mon_cnt / CPB == 0) begin
               if (tx !== 1'b0) fr_err++;
            end else if (mon_cnt / CPB <= 8) begin
               mon_byte[mon_cnt / CPB - 1] = tx;
            end else begin
               if (tx !== 1'b1) fr_err++;
               rx.push_back(mon_byte);
               mon_act = 0;
            end
         end
      end
      if (tx_done === 1'b1) begin
         done_n++;
         done_cyc.push_back(cyc);
      end
      if (!reset && bus.in_valid === 1'b1 && bus.in_ready === 1'b1) dut_acc++;
      if (chk_en) begin
         chk("cyc_tx",         32'(tx),         32'(exp_tx()));
         chk("cyc_tx_done",    32'(tx_done),    32'(m_left == 1));
         chk("cyc_busy",       32'(busy),       32'((m_left != 0) || (mq.size() != 0)));
         chk("cyc_fifo_count", 32'(fifo_count), 32'(mq.size()));
         chk("cyc_in_ready",   32'(bus.in_ready), 32'(mq.size() < DEPTH));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_dones(input string tag, input int target, input int budget);
      int b;
      b = budget;
      while (done_n < target && b > 0) begin
         tick();
         b--;
      end
      chk(tag, 32'(done_n), 32'(target));
   endtask

   task automatic push_seq(input logic [7:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      tick();
   endtask

   initial begin : stim
      logic [7:0] str [5];
      logic [7:0] rnd [4];
      int         acc_cyc, base, acc0, d0, budget;
      str = '{8'h55, 8'h41, 8'h52, 8'h54, 8'h0A};
      for (int i = 0; i < 4; i++) rnd[i] = 8'($urandom);

      // Reset
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (5) tick();
      reset  = 1'b0;
      chk_en = 1;
      chk("rst_tx",         32'(tx),           32'd1);
      chk("rst_busy",       32'(busy),         32'd0);
      chk("rst_in_ready",   32'(bus.in_ready), 32'd1);
      chk("rst_fifo_count", 32'(fifo_count),   32'd0);
      repeat (100) tick();
      chk("rst_no_done",    32'(done_n),       32'd0);

      // Single byte
      push_seq(8'h55);
      bus.in_valid = 1'b0;
      acc_cyc = cyc;
      wait_dones("single_done", 1, 400);
      chk("single_fall_latency", 32'(fall_cyc - acc_cyc), 32'd1);
      chk("single_done_time",    32'(done_cyc[0] - fall_cyc), 32'(FRAME - 1));
      chk("single_busy_after",   32'(busy), 32'd0);
      chk("single_rx",           32'(rx[0]), 32'h55);

      // String back-to-back
      base = rx.size();
      for (int i = 0; i < 5; i++) push_seq(str[i]);
      chk("str_ready_low", 32'(bus.in_ready), 32'd0);
      chk("str_count",     32'(fifo_count),   32'd4);
      bus.in_valid = 1'b0;
      wait_dones("str_done", 6, 1400);
      for (int k = 2; k <= 5; k++)
         chk("str_spacing", 32'(done_cyc[k] - done_cyc[k-1]), 32'(FRAME));
      for (int i = 0; i < 5; i++)
         chk("str_rx", 32'(rx[base + i]), 32'(str[i]));

      // Full / backpressure
      base = rx.size();
      acc0 = dut_acc;
      for (int i = 0; i < 20; i++) push_seq(8'hC0 + 8'(i));
      bus.in_valid = 1'b0;
      chk("bp_accepted", 32'(dut_acc - acc0), 32'd5);
      chk("bp_ready_low", 32'(bus.in_ready), 32'd0);
      wait_dones("bp_done", 11, 1400);
      for (int i = 0; i < 5; i++)
         chk("bp_rx", 32'(rx[base + i]), 32'(8'hC0 + 8'(i)));

      // Simultaneous push/pop at the stop-bit end
      base = rx.size();
      for (int i = 0; i < 3; i++) push_seq(rnd[i]);
      bus.in_valid = 1'b0;
      budget = 400;
      while (tx_done !== 1'b1 && budget > 0) begin
         tick();
         budget--;
      end
      chk("pp_done_seen", 32'(tx_done),    32'd1);
      chk("pp_count_pre", 32'(fifo_count), 32'd2);
      bus.in_valid = 1'b1;
      bus.in_data  = rnd[3];
      tick();
      bus.in_valid = 1'b0;
      chk("pp_count_post", 32'(fifo_count), 32'd2);
      chk("pp_next_start", 32'(tx),         32'd0);
      wait_dones("pp_done", 15, 1200);
      for (int i = 0; i < 4; i++)
         chk("pp_rx", 32'(rx[base + i]), 32'(rnd[i]));

      // Reset mid-frame, during data bit 3 of 0xA5
      base = rx.size();
      push_seq(8'hA5);
      push_seq(8'($urandom));
      push_seq(8'($urandom));
      bus.in_valid = 1'b0;
      while (cyc < fall_cyc + 4 * CPB + 5) tick();
      d0    = done_n;
      reset = 1'b1;
      tick();
      chk("mid_rst_tx",    32'(tx),         32'd1);
      chk("mid_rst_count", 32'(fifo_count), 32'd0);
      chk("mid_rst_busy",  32'(busy),       32'd0);
      tick();
      reset = 1'b0;
      repeat (300) tick();
      chk("mid_rst_no_done", 32'(done_n),   32'(d0));
      chk("mid_rst_no_rx",   32'(rx.size()), 32'(base));
      push_seq(8'h3C);
      bus.in_valid = 1'b0;
      wait_dones("after_rst_done", d0 + 1, 400);
      chk("after_rst_rx", 32'(rx[rx.size() - 1]), 32'h3C);

      // Whole-run consistency between decoder and model
      chk("framing_errors", 32'(fr_err), 32'd0);
      chk("rx_total", 32'(rx.size()), 32'(exp_done.size()));
      for (int i = 0; i < rx.size() && i < exp_done.size(); i++)
         chk("rx_vs_model", 32'(rx[i]), 32'(exp_done[i]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
